alu_decode_exec: RTL

- Instruction-side front end for the integer ALU. Accepts a raw RV32I OP, OP-IMM or BRANCH instruction word together with its rs1/rs2 values over a valid/ready handshake.
- Decodes the word into one-hot ALU operation flags and executes it. Shifts use either a multi-cycle serial shifter or a single-cycle barrel shifter.
- Returns the result and branch decision over a second valid/ready handshake. Sits between the instruction fetch/regfile stage and writeback.

---
 rtl/alu_decode_exec_pkg.sv | 54 +++++
 rtl/alu_insn_decode.sv | 87 ++++++++
 rtl/alu_decode_exec.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_decode_exec_pkg.sv
// Shared definitions for the ALU decode/execute block: opcode, funct3 and funct7
// constants, FSM state encodings and the one-hot operation flag indices.
package alu_decode_exec_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLL  = 2;
    localparam int OP_SLT  = 3;
    localparam int OP_SLTU = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SRL  = 6;
    localparam int OP_SRA  = 7;
    localparam int OP_OR   = 8;
    localparam int OP_AND  = 9;
    localparam int OP_BEQ  = 10;
    localparam int OP_BNE  = 11;
    localparam int OP_BLT  = 12;
    localparam int OP_BGE  = 13;
    localparam int OP_BLTU = 14;
    localparam int OP_BGEU = 15;
    localparam int N_OPS   = 16;

    typedef logic [N_OPS-1:0] op_flags_t;

endpackage

// File: rtl/alu_insn_decode.sv
// Combinational RV32I OP / OP-IMM / BRANCH decoder producing one-hot operation
// flags, the sign-extended immediate and the immediate shift amount.
module alu_insn_decode
    import alu_decode_exec_pkg::*;
(
    input  logic [31:0] insn,
    output op_flags_t   instr,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  shamt,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = insn[6:0];
    assign funct3 = insn[14:12];
    assign funct7 = insn[31:25];
    // Register specifiers are resolved upstream; only the operand values arrive here.
    assign unused_fields = ^{insn[19:15], insn[11:7]};

    always_comb begin
        instr   = '0;
        use_imm = 1'b0;
        illegal = 1'b0;
        imm     = {{20{insn[31]}}, insn[31:20]};
        shamt   = insn[24:20];
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  instr[OP_ADD]  = 1'b1;
                        F3_SLL:  instr[OP_SLL]  = 1'b1;
                        F3_SLT:  instr[OP_SLT]  = 1'b1;
                        F3_SLTU: instr[OP_SLTU] = 1'b1;
                        F3_XOR:  instr[OP_XOR]  = 1'b1;
                        F3_SR:   instr[OP_SRL]  = 1'b1;
                        F3_OR:   instr[OP_OR]   = 1'b1;
                        default: instr[OP_AND]  = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    instr[OP_SUB] = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    instr[OP_SRA] = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD:  instr[OP_ADD]  = 1'b1;
                    F3_SLT:  instr[OP_SLT]  = 1'b1;
                    F3_SLTU: instr[OP_SLTU] = 1'b1;
                    F3_XOR:  instr[OP_XOR]  = 1'b1;
                    F3_OR:   instr[OP_OR]   = 1'b1;
                    F3_AND:  instr[OP_AND]  = 1'b1;
                    F3_SLL: begin
                        if (funct7 == F7_BASE) instr[OP_SLL] = 1'b1;
                        else                   illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     instr[OP_SRL] = 1'b1;
                        else if (funct7 == F7_ALT) instr[OP_SRA] = 1'b1;
                        else                       illegal = 1'b1;
                    end
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ:  instr[OP_BEQ]  = 1'b1;
                    F3_BNE:  instr[OP_BNE]  = 1'b1;
                    F3_BLT:  instr[OP_BLT]  = 1'b1;
                    F3_BGE:  instr[OP_BGE]  = 1'b1;
                    F3_BLTU: instr[OP_BLTU] = 1'b1;
                    F3_BGEU: instr[OP_BGEU] = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_decode_exec.sv
// Integer ALU front end: accepts an instruction with operands, decodes and executes
// it (optionally with a serial shifter), and returns a registered result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | in_ready high; waiting for an instruction
// ST_SHIFT | serial shift in progress (4 bits/cycle, then 1 bit/cycle)
// ST_DONE  | out_valid high; result held until out_ready
module alu_decode_exec
    import alu_decode_exec_pkg::*;
#(
    parameter int BARREL_SHIFTER = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_branch_taken,
    output logic        out_illegal
);

    state_t      state, state_nxt;
    op_flags_t   instr;
    logic        use_imm, illegal;
    logic [31:0] imm;
    logic [4:0]  dec_shamt;

    logic [31:0] op2, res;
    logic [4:0]  sh_amt;
    logic        taken, is_shift, go_shift, accept;
    logic        lt, ltu, eq;

    logic [31:0] sh_val, sh_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        sh_left, sh_arith, step4;

    alu_insn_decode u_decode (
        .insn    (in_insn),
        .instr   (instr),
        .use_imm (use_imm),
        .imm     (imm),
        .shamt   (dec_shamt),
        .illegal (illegal)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        op2    = use_imm ? imm : in_rs2;
        sh_amt = use_imm ? dec_shamt : in_rs2[4:0];
        lt     = $signed(in_rs1) < $signed(op2);
        ltu    = in_rs1 < op2;
        eq     = in_rs1 == op2;
        taken  = (instr[OP_BEQ] & eq) | (instr[OP_BNE] & ~eq) |
                 (instr[OP_BLT] & lt) | (instr[OP_BGE] & ~lt) |
                 (instr[OP_BLTU] & ltu) | (instr[OP_BGEU] & ~ltu);
        res = '0;
        if (instr[OP_ADD])  res = in_rs1 + op2;
        if (instr[OP_SUB])  res = in_rs1 - op2;
        if (instr[OP_SLL])  res = in_rs1 << sh_amt;
        if (instr[OP_SRL])  res = in_rs1 >> sh_amt;
        if (instr[OP_SRA])  res = 32'($signed(in_rs1) >>> sh_amt);
        if (instr[OP_SLT])  res = {31'b0, lt};
        if (instr[OP_SLTU]) res = {31'b0, ltu};
        if (instr[OP_XOR])  res = in_rs1 ^ op2;
        if (instr[OP_OR])   res = in_rs1 | op2;
        if (instr[OP_AND])  res = in_rs1 & op2;
        if (|instr[OP_BGEU:OP_BEQ]) res = {31'b0, taken};
    end

    assign is_shift = instr[OP_SLL] | instr[OP_SRL] | instr[OP_SRA];
    assign go_shift = (BARREL_SHIFTER == 0) && is_shift && (sh_amt != 5'd0);

    always_comb begin
        step4   = (cnt >= 5'd4);
        cnt_nxt = cnt - (step4 ? 5'd4 : 5'd1);
        if (sh_left)
            sh_nxt = step4 ? {sh_val[27:0], 4'b0} : {sh_val[30:0], 1'b0};
        else if (sh_arith)
            sh_nxt = step4 ? {{4{sh_val[31]}}, sh_val[31:4]} : {sh_val[31], sh_val[31:1]};
        else
            sh_nxt = step4 ? {4'b0, sh_val[31:4]} : {1'b0, sh_val[31:1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = go_shift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_nxt == 5'd0) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Working shift register is kept apart from out_result so the previous
    // result stays visible until the new one is complete.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_val           <= '0;
            cnt              <= '0;
            sh_left          <= 1'b0;
            sh_arith         <= 1'b0;
            out_result       <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (accept) begin
            sh_val   <= in_rs1;
            cnt      <= go_shift ? sh_amt : 5'd0;
            sh_left  <= instr[OP_SLL];
            sh_arith <= instr[OP_SRA];
            if (!go_shift) begin
                out_result       <= res;
                out_branch_taken <= taken;
                out_illegal      <= illegal;
            end
        end else if (state == ST_SHIFT) begin
            sh_val <= sh_nxt;
            cnt    <= cnt_nxt;
            if (cnt_nxt == 5'd0) begin
                out_result       <= sh_nxt;
                out_branch_taken <= 1'b0;
                out_illegal      <= 1'b0;
            end
        end
    end

endmodule
